// File: rtl/riscv_pkg.sv
// Shared RISC-V types for the writeback stage: opcodes, register names,
// load funct3 encodings and the writeback buffer entry layout.
package riscv_pkg;

  // Widest supported datapath; buffer entries are sized for it so the
  // entry type can live in the package independent of XLEN.
  localparam int XLEN_MAX = 64;

  typedef enum logic [6:0] {
    OP_LOAD    = 7'b0000011,
    OP_REG_IMM = 7'b0010011,
    OP_AUIPC   = 7'b0010111,
    OP_STORE   = 7'b0100011,
    OP_REG_REG = 7'b0110011,
    OP_LUI     = 7'b0110111,
    OP_BRANCH  = 7'b1100011,
    OP_JALR    = 7'b1100111,
    OP_JAL     = 7'b1101111,
    OP_SYSTEM  = 7'b1110011
  } opcode_t;

  typedef logic [4:0] register_name_t;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LD  = 3'b011;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;
  localparam logic [2:0] LOAD_F3_LWU = 3'b110;

  typedef struct packed {
    logic                valid;
    logic                wr;
    register_name_t      rd;
    logic [XLEN_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data formatter: selects the addressed byte/half/word lane of the raw
// memory word and sign- or zero-extends it. Purely combinational.
module wb_load_align
  import riscv_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int AW   = $clog2(XLEN / 8)
) (
  input  logic [2:0]      funct3_i,
  input  logic [AW-1:0]   addr_lo_i,
  input  logic [XLEN-1:0] lmd_i,
  output logic [XLEN-1:0] data_o,
  output logic            legal_o
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] word_sh;

  // Lane shifts: byte by addr*8, half by addr[msb:1]*16, word by addr[msb:2]*32.
  assign byte_sh = lmd_i >> {addr_lo_i, 3'b000};
  assign half_sh = lmd_i >> {(addr_lo_i >> 1), 4'b0000};
  assign word_sh = lmd_i >> {(addr_lo_i >> 2), 5'b00000};

  // Decode funct3 into the extended result; doubleword forms exist only at XLEN=64.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    data_o  = '0;
    legal_o = 1'b1;
    case (funct3_i)
      LOAD_F3_LB:  data_o = XLEN'($signed(byte_sh[7:0]));
      LOAD_F3_LH:  data_o = XLEN'($signed(half_sh[15:0]));
      LOAD_F3_LW:  data_o = XLEN'($signed(word_sh[31:0]));
      LOAD_F3_LBU: data_o = XLEN'(byte_sh[7:0]);
      LOAD_F3_LHU: data_o = XLEN'(half_sh[15:0]);
      LOAD_F3_LD: begin
        if (XLEN == 64) data_o = lmd_i;
        else            legal_o = 1'b0;
      end
      LOAD_F3_LWU: begin
        if (XLEN == 64) data_o = XLEN'(word_sh[31:0]);
        else            legal_o = 1'b0;
      end
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/writeback_buffer_unit.sv
// Writeback stage: queues retiring MEM results in a DEPTH-entry circular
// buffer, drains the head into the register file under rf_ready back-pressure
// and offers a youngest-first forwarding lookup over all buffered results.
// Optional macro WB_RETIRE_CNT_EN adds the 64-bit retire_count output.
module writeback_buffer_unit
  import riscv_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(XLEN / 8),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mw_valid,
  output logic            mw_ready,
  input  logic [6:0]      mw_opcode,
  input  logic [2:0]      mw_funct3,
  input  logic [4:0]      mw_rd,
  input  logic [XLEN-1:0] mw_alu_result,
  input  logic [XLEN-1:0] mw_lmd,
  input  logic [AW-1:0]   mw_addr_lo,
  input  logic            rf_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      fwd_rs,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  wb_entry_t       buf_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mw_ready_q, mw_ready_d;
  wb_entry_t       head_entry;
  wb_entry_t       new_entry;
  logic            push, pop;
  logic [XLEN-1:0] align_data;
  logic            align_legal;
  logic [PW-1:0]   fwd_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i  (mw_funct3),
    .addr_lo_i (mw_addr_lo),
    .lmd_i     (mw_lmd),
    .data_o    (align_data),
    .legal_o   (align_legal)
  );

  assign head_entry = buf_q[head_q];
  assign mw_ready   = mw_ready_q;
  assign push       = mw_valid && mw_ready_q && !flush;
  assign pop        = head_entry.valid && (!head_entry.wr || rf_ready);

  // Classify the incoming beat and build the entry to be queued.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.rd    = mw_rd;
    case (mw_opcode)
      OP_REG_REG, OP_REG_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        new_entry.wr   = 1'b1;
        new_entry.data = XLEN_MAX'(mw_alu_result);
      end
      OP_LOAD: begin
        new_entry.wr   = align_legal;
        new_entry.data = XLEN_MAX'(align_data);
      end
      default: new_entry.data = XLEN_MAX'(mw_alu_result);
    endcase
    if (mw_rd == '0) new_entry.wr = 1'b0;
  end

  // Next-state for pointers, occupancy and the registered ready flag.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
    mw_ready_d = (count_d < CW'(DEPTH));
  end

  // State registers and buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mw_ready_q <= 1'b1;
      // NOTE: only the valid bits are reset; payload fields are never read while invalid.
      for (int i = 0; i < DEPTH; i++) buf_q[i].valid <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mw_ready_q <= mw_ready_d;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) buf_q[i].valid <= 1'b0;
      end else begin
        if (pop)  buf_q[head_q].valid <= 1'b0;
        if (push) buf_q[tail_q]       <= new_entry;
      end
    end
  end

  // Drive the register-file port straight from the head entry.
  always_comb begin
    rf_we    = head_entry.valid && head_entry.wr;
    rf_rd    = head_entry.valid ? head_entry.rd : '0;
    rf_wdata = head_entry.valid ? head_entry.data[XLEN-1:0] : '0;
  end

  // Forwarding search from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_rs != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        fwd_idx = PW'((int'(head_q) + k) % DEPTH);
        if (buf_q[fwd_idx].valid && buf_q[fwd_idx].wr && buf_q[fwd_idx].rd == fwd_rs) begin
          fwd_hit  = 1'b1;
          fwd_data = buf_q[fwd_idx].data[XLEN-1:0];
        end
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Count every pop; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)      retire_cnt_q <= '0;
    else if (pop) retire_cnt_q <= retire_cnt_q + 64'd1;
  end

  assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_buffer_unit.sv
// Directed bench for writeback_buffer_unit (XLEN=32, DEPTH=2): a vector table
// of single-beat transactions plus hand-written multi-cycle sequences.
module tb_writeback_buffer_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, mw_valid, mw_ready;
  logic [6:0]  mw_opcode;
  logic [2:0]  mw_funct3;
  logic [4:0]  mw_rd;
  logic [31:0] mw_alu_result, mw_lmd;
  logic [1:0]  mw_addr_lo;
  logic        rf_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_buffer_unit #(.XLEN(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .mw_valid      (mw_valid),
    .mw_ready      (mw_ready),
    .mw_opcode     (mw_opcode),
    .mw_funct3     (mw_funct3),
    .mw_rd         (mw_rd),
    .mw_alu_result (mw_alu_result),
    .mw_lmd        (mw_lmd),
    .mw_addr_lo    (mw_addr_lo),
    .rf_ready      (rf_ready),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .fwd_rs        (fwd_rs),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count  (retire_count)
`endif
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic [1:0]  addr;
    logic        exp_we;
    logic        chk_data;
    logic [31:0] exp_data;
  } wb_vec_t;

  wb_vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] lmd, input logic [1:0] addr);
    mw_valid      = 1'b1;
    mw_opcode     = op;
    mw_funct3     = f3;
    mw_rd         = rd;
    mw_alu_result = alu;
    mw_lmd        = lmd;
    mw_addr_lo    = addr;
  endtask

  initial begin
    vecs[0]  = '{OP_REG_REG, 3'b000, 5'd1,  32'h12345678, 32'h0,        2'd0, 1'b1, 1'b1, 32'h12345678};
    vecs[1]  = '{OP_LOAD,    3'b000, 5'd2,  32'h0,        32'h80FF7F01, 2'd3, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[2]  = '{OP_LOAD,    3'b100, 5'd3,  32'h0,        32'h80FF7F01, 2'd3, 1'b1, 1'b1, 32'h00000080};
    vecs[3]  = '{OP_LOAD,    3'b101, 5'd4,  32'h0,        32'h80FF7F01, 2'd2, 1'b1, 1'b1, 32'h000080FF};
    vecs[4]  = '{OP_LOAD,    3'b001, 5'd5,  32'h0,        32'h80FF7F01, 2'd2, 1'b1, 1'b1, 32'hFFFF80FF};
    vecs[5]  = '{OP_LOAD,    3'b001, 5'd6,  32'h0,        32'h80FF7F01, 2'd0, 1'b1, 1'b1, 32'h00007F01};
    vecs[6]  = '{OP_LOAD,    3'b000, 5'd7,  32'h0,        32'h80FF7F01, 2'd1, 1'b1, 1'b1, 32'h0000007F};
    vecs[7]  = '{OP_LOAD,    3'b000, 5'd8,  32'h0,        32'h80FF7F01, 2'd2, 1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{OP_LOAD,    3'b010, 5'd9,  32'h0,        32'h80FF7F01, 2'd0, 1'b1, 1'b1, 32'h80FF7F01};
    vecs[9]  = '{OP_LOAD,    3'b011, 5'd10, 32'h0,        32'h80FF7F01, 2'd0, 1'b0, 1'b1, 32'h00000000};
    vecs[10] = '{OP_LOAD,    3'b110, 5'd11, 32'h0,        32'h80FF7F01, 2'd0, 1'b0, 1'b1, 32'h00000000};
    vecs[11] = '{OP_LOAD,    3'b111, 5'd12, 32'h0,        32'h80FF7F01, 2'd0, 1'b0, 1'b1, 32'h00000000};
    vecs[12] = '{OP_LUI,     3'b000, 5'd13, 32'hABCDE000, 32'h0,        2'd0, 1'b1, 1'b1, 32'hABCDE000};
    vecs[13] = '{OP_JAL,     3'b000, 5'd14, 32'h00000100, 32'h0,        2'd0, 1'b1, 1'b1, 32'h00000100};
    vecs[14] = '{OP_STORE,   3'b010, 5'd15, 32'h00000055, 32'h0,        2'd0, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{OP_REG_REG, 3'b000, 5'd0,  32'hDEADBEEF, 32'h0,        2'd0, 1'b0, 1'b0, 32'h0};

    rst = 1'b1; flush = 1'b0; mw_valid = 1'b0; rf_ready = 1'b0; fwd_rs = 5'd5;
    drive_beat(OP_REG_REG, 3'b000, 5'd0, 32'h0, 32'h0, 2'd0);
    mw_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_mw_ready", 64'(mw_ready), 64'd1);
    check("reset_rf_we",    64'(rf_we),    64'd0);
    check("reset_rf_rd",    64'(rf_rd),    64'd0);
    check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset_fwd_hit",  64'(fwd_hit),  64'd0);
    check("reset_fwd_data", 64'(fwd_data), 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check("reset_retire",   retire_count,  64'd0);
`endif
    rst = 1'b0;

    // x0 write and STORE drain without rf_ready and never assert rf_we
    @(negedge clk);
    drive_beat(OP_REG_REG, 3'b000, 5'd0, 32'hDEADBEEF, 32'h0, 2'd0);
    @(negedge clk);
    drive_beat(OP_STORE, 3'b010, 5'd3, 32'h00000040, 32'h0, 2'd0);
    #1 check("x0_rf_we_c1", 64'(rf_we), 64'd0);
    @(negedge clk);
    mw_valid = 1'b0;
    #1 check("x0_rf_we_c2", 64'(rf_we), 64'd0);
    @(negedge clk); #1;
    check("x0_rf_we_c3",   64'(rf_we),    64'd0);
    check("x0_drained",    64'(mw_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
    check("x0_retire",     retire_count,  64'd2);
`endif

    // Table-driven single-beat transactions, rf_ready held high
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rf_ready = 1'b1;
      drive_beat(vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].alu, vecs[i].lmd, vecs[i].addr);
      fwd_rs = vecs[i].rd;
      #1 check($sformatf("v%0d_mw_ready", i), 64'(mw_ready), 64'd1);
      @(negedge clk);
      mw_valid = 1'b0;
      #1;
      check($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
      check($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit), 64'(vecs[i].exp_we));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_rf_rd", i),    64'(rf_rd),    64'(vecs[i].rd));
        check($sformatf("v%0d_rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_data));
      end
      if (vecs[i].exp_we)
        check($sformatf("v%0d_fwd_data", i), 64'(fwd_data), 64'(vecs[i].exp_data));
    end

    // Back-pressure and youngest-first forwarding
    @(negedge clk);
    rf_ready = 1'b0;
    fwd_rs   = 5'd5;
    drive_beat(OP_REG_REG, 3'b000, 5'd5, 32'hA, 32'h0, 2'd0);
    #1 check("bp_not_visible_yet", 64'(fwd_hit), 64'd0);
    @(negedge clk);
    drive_beat(OP_REG_REG, 3'b000, 5'd5, 32'hB, 32'h0, 2'd0);
    #1 check("bp_fwd_older", 64'(fwd_data), 64'hA);
    @(negedge clk);
    mw_valid = 1'b0;
    #1;
    check("bp_mw_ready_full", 64'(mw_ready), 64'd0);
    check("bp_fwd_hit",       64'(fwd_hit),  64'd1);
    check("bp_fwd_youngest",  64'(fwd_data), 64'hB);
    check("bp_head_data",     64'(rf_wdata), 64'hA);
    fwd_rs = 5'd0;
    #1 check("bp_fwd_x0", 64'(fwd_hit), 64'd0);
    @(negedge clk); #1;
    check("bp_held_we",   64'(rf_we),    64'd1);
    check("bp_held_data", 64'(rf_wdata), 64'hA);
    rf_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_second_we",   64'(rf_we),    64'd1);
    check("bp_second_data", 64'(rf_wdata), 64'hB);
    check("bp_ready_again", 64'(mw_ready), 64'd1);
    @(negedge clk); #1;
    check("bp_empty_we", 64'(rf_we), 64'd0);

    // Flush with a full buffer and a beat presented
    rf_ready = 1'b0;
    drive_beat(OP_REG_REG, 3'b000, 5'd6, 32'h1, 32'h0, 2'd0);
    @(negedge clk);
    drive_beat(OP_REG_REG, 3'b000, 5'd7, 32'h2, 32'h0, 2'd0);
    @(negedge clk);
    drive_beat(OP_REG_REG, 3'b000, 5'd8, 32'h3, 32'h0, 2'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mw_valid = 1'b0; fwd_rs = 5'd6;
    #1;
    check("fl_rf_we",    64'(rf_we),    64'd0);
    check("fl_mw_ready", 64'(mw_ready), 64'd1);
    check("fl_fwd_x6",   64'(fwd_hit),  64'd0);

    // Flush drops a beat that would otherwise have been accepted
    drive_beat(OP_REG_REG, 3'b000, 5'd9, 32'h4, 32'h0, 2'd0);
    @(negedge clk);
    drive_beat(OP_REG_REG, 3'b000, 5'd8, 32'h3, 32'h0, 2'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mw_valid = 1'b0; fwd_rs = 5'd8;
    #1;
    check("fl2_fwd_x8", 64'(fwd_hit), 64'd0);
    check("fl2_rf_we",  64'(rf_we),   64'd0);

    // A pop coinciding with flush still presents its write
    drive_beat(OP_REG_REG, 3'b000, 5'd10, 32'h5, 32'h0, 2'd0);
    @(negedge clk);
    mw_valid = 1'b0; flush = 1'b1; rf_ready = 1'b1;
    #1;
    check("fl3_pop_we",   64'(rf_we),    64'd1);
    check("fl3_pop_data", 64'(rf_wdata), 64'h5);
    @(negedge clk);
    flush = 1'b0;
    #1 check("fl3_after_we", 64'(rf_we), 64'd0);

    // Reset while entries are pending discards them
    rf_ready = 1'b0;
    drive_beat(OP_REG_REG, 3'b000, 5'd11, 32'h11, 32'h0, 2'd0);
    @(negedge clk);
    drive_beat(OP_REG_REG, 3'b000, 5'd12, 32'h12, 32'h0, 2'd0);
    @(negedge clk);
    mw_valid = 1'b0; rst = 1'b1; rf_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; fwd_rs = 5'd11;
    #1;
    check("rst_mid_rf_we",    64'(rf_we),    64'd0);
    check("rst_mid_mw_ready", 64'(mw_ready), 64'd1);
    check("rst_mid_fwd",      64'(fwd_hit),  64'd0);
`ifdef WB_RETIRE_CNT_EN
    check("rst_mid_retire",   retire_count,  64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
